pg_rr_sched: RTL and testbench
==============================

# pg_rr_sched

Round-robin scheduler that shares one registered `WIDTH`-bit lane among `NREQ` requesters. It sits in front of a parameterised leaf datapath instance and replaces per-requester leaf copies (generate loop or instance array) with a single time-multiplexed lane. Each requester uses a valid/ready handshake. The block forwards one granted beat per cycle through an output register, tagged with the source index.

## Interface

**Parameters**
- `WIDTH`, default 4: data width per beat; must be ≥1.
- `NREQ`, default 2: number of requesters; must be 2..16.
- `SRCW`, default `$clog2(NREQ)`: width of `out_src`; derived, not overridden.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req_valid`, input, `NREQ`: bit i set means requester i presents a beat.
- `req_data`, input, `NREQ*WIDTH`: requester i's data occupies bits `[i*WIDTH +: WIDTH]`.
- `req_ready`, output, `NREQ`: one-hot or zero; bit i set means requester i's beat is taken this cycle.
- `out_valid`, output, 1: the output register holds a beat.
- `out_ready`, input, 1: the downstream consumer accepts the beat.
- `out_data`, output, `WIDTH`: the granted beat.
- `out_src`, output, `SRCW`: index of the requester that supplied `out_data`.

## Operation

- **State:** `out_valid`, `out_data`, `out_src`, and `ptr` (index of the last granted requester, `SRCW` bits).
- **Load enable:** `load = !out_valid || out_ready`.
- **Grant selection:** when `load` is 1, grant the first requester with `req_valid` set, searching indices `ptr+1`, `ptr+2`, … with modulo-`NREQ` wrap and ending at `ptr`.
  - The grant is combinational, from current-cycle `req_valid`, `ptr` and `out_ready`.
- **`req_ready`:** bit `grant` is 1 only when `load` is 1 and some request is valid. All other bits are 0.
  - `req_ready` must not be used by requesters to form `req_valid`.
- **On a grant edge:**
  - `out_data <= req_data[grant]`
  - `out_src <= grant`
  - `out_valid <= 1`
  - `ptr <= grant`
- **Load with no valid request:** `out_valid <= 0`. `out_data`, `out_src` and `ptr` hold.
- **Stall** (`out_valid && !out_ready`): all `req_ready` are 0, and all state holds.
- **Fairness:** a requester that holds `req_valid` continuously is granted within `NREQ` accepted beats.
- **Requester handshake:** a requester must hold `req_valid` and `req_data` stable until it sees `req_ready`.

## Timing

- **Reset values:**
  - `out_valid = 0`
  - `out_data = 0`
  - `out_src = 0`
  - `ptr = NREQ-1`, so requester 0 has first priority after reset.
  - `req_ready = 0`, because `req_valid` is low during reset.
- **Latency:** a beat accepted at edge N appears on `out_data` and `out_valid` right after edge N, i.e. 1 cycle.
- **Throughput:** 1 beat per cycle while `out_ready` is held at 1.
- **Simultaneous events:** `out_ready=1` and a new grant in the same cycle means the old beat leaves and the new beat loads on the same edge, with no bubble.
- **Reset mid-operation:** assertion asynchronously clears all state. A beat held in the output register is dropped, and the grant pointer restarts at requester 0.
- **`ptr` wrap-around:** after a grant to `NREQ-1`, the search starts at index 0.

## Configuration

- **`PG_RR_SCHED_CNT_EN` defined:** the block adds two ports.
  - Input `cnt_clr` (1 bit).
  - Output `grant_cnt` (`NREQ*8`): requester i's count occupies `[i*8 +: 8]`.
- **Counter behaviour:**
  - Each counter increments on every grant edge to its requester and saturates at 255.
  - `cnt_clr=1` synchronously zeroes all counters and overrides a same-cycle increment.
  - Reset value is 0.
- **`PG_RR_SCHED_CNT_EN` undefined:** the ports and counters are absent. All other behaviour is identical.

## Test plan

- **Reset:** assert `rst_n=0` mid-stream with `out_valid=1`.
  - Immediately `out_valid=0`, `out_data=0`, `out_src=0`.
  - After release, with both requests valid, the first grant goes to requester 0.
- **Round-robin:** `NREQ=2`, `WIDTH=4`, both valid with `data0=0x3` and `data1=0xC`, `out_ready=1` for 4 cycles.
  - `out_src` sequence 0,1,0,1; `out_data` 0x3,0xC,0x3,0xC; each `req_ready` toggles every cycle.
- **Backpressure:** `out_ready=0` for 3 cycles with `out_valid=1` and `out_data=0x3`.
  - Output holds 0x3 and `req_ready=0`.
  - On `out_ready=1`, the next grant is requester 1 in the same cycle.
- **Single requester:** only `req_valid[1]=1` with `data=0x5` for 3 cycles.
  - Three consecutive beats with `out_src=1`, with no idle cycles.
  - When the request is then deasserted with `out_ready=1`, `out_valid` falls after one edge.
- **Wrap and fairness:** `NREQ=4`, `ptr=3`, requesters 1 and 3 valid.
  - Grant order 1,3,1,3; requester 0 is never granted.
- **Counters** (`PG_RR_SCHED_CNT_EN`):
  - 300 consecutive grants to requester 0 leave its count at 255.
  - `cnt_clr=1` on the same edge as a grant leaves it at 0.

Source files
------------

// File: rtl/pg_rr_sched.sv
// pg_rr_sched: round-robin scheduler sharing one registered WIDTH-bit lane
// among NREQ valid/ready requesters. One granted beat per cycle is forwarded
// through an output register, tagged with the index of its requester.
//
// Optional feature: define PG_RR_SCHED_CNT_EN to add per-requester
// saturating 8-bit grant counters (cnt_clr input, grant_cnt output).
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]        requester i presents a beat
//   req_data   [NREQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   req_ready  [NREQ]        one-hot/zero, beat i is taken this cycle (comb)
//   out_valid                output register holds a beat
//   out_ready                downstream accepts the beat
//   out_data   [WIDTH]       granted beat
//   out_src    [SRCW]        index of the requester that supplied out_data
//   cnt_clr                  (PG_RR_SCHED_CNT_EN) synchronous counter clear
//   grant_cnt  [NREQ*8]      (PG_RR_SCHED_CNT_EN) count i at [i*8 +: 8]
module pg_rr_sched #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned NREQ  = 2,
   parameter int unsigned SRCW  = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SRCW-1:0]         out_src
`ifdef PG_RR_SCHED_CNT_EN
   ,
   input  logic                    cnt_clr,
   output logic [NREQ*8-1:0]       grant_cnt
`endif
);

   localparam int unsigned   CNTW    = 8;
   localparam logic [SRCW-1:0] PTR_RST = SRCW'(NREQ - 1);

   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     out_data_q,  out_data_d;
   logic [SRCW-1:0]      out_src_q,   out_src_d;
   logic [SRCW-1:0]      ptr_q,       ptr_d;

   logic                 load_c;
   logic                 take_c;
   logic                 gnt_found;
   logic [SRCW-1:0]      gnt_idx;
   logic [WIDTH-1:0]     gnt_data;
   int unsigned          gnt_best;
   int unsigned          gnt_dist;

   // Output register may be reloaded when empty or being drained this cycle.
   assign load_c = !out_valid_q || out_ready;

   // Round-robin search: distance 0 is ptr+1, distance NREQ-1 is ptr itself;
   // the valid requester with the smallest distance wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      gnt_data  = '0;
      gnt_best  = NREQ;
      gnt_dist  = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         gnt_dist = (i + 2 * NREQ - 1 - 32'(ptr_q)) % NREQ;
         if (req_valid[i] && (gnt_dist < gnt_best)) begin
            gnt_best  = gnt_dist;
            gnt_found = 1'b1;
            gnt_idx   = SRCW'(i);
            gnt_data  = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign take_c = load_c && gnt_found;

   // Handshake back to the winning requester only.
   always_comb begin
      req_ready = '0;
      if (take_c) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   // Next-state for the output register and grant pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      ptr_d       = ptr_q;
      if (load_c) begin
         out_valid_d = gnt_found;
         if (gnt_found) begin
            out_data_d = gnt_data;
            out_src_d  = gnt_idx;
            ptr_d      = gnt_idx;
         end
      end
   end

   // State registers; reset restarts priority at requester 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         ptr_q       <= PTR_RST;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

`ifdef PG_RR_SCHED_CNT_EN
   logic [NREQ-1:0][CNTW-1:0] cnt_q, cnt_d;

   // Saturating per-requester grant counters; clear wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (take_c && (cnt_q[gnt_idx] != {CNTW{1'b1}})) begin
         cnt_d[gnt_idx] = cnt_q[gnt_idx] + CNTW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pg_rr_sched.sv
// Self-checking bench for pg_rr_sched: a 2-requester instance driven from a
// vector table with a beat scoreboard, and a 4-requester instance for
// pointer wrap-around and fairness.
module tb_pg_rr_sched;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // 2-requester instance
   logic [1:0] v2;
   logic [7:0] d2;
   logic       ordy2;
   logic [1:0] rdy2;
   logic       ov2;
   logic [3:0] od2;
   logic       os2;

   // 4-requester instance
   logic [3:0]  v4;
   logic [15:0] d4;
   logic        ordy4;
   logic [3:0]  rdy4;
   logic        ov4;
   logic [3:0]  od4;
   logic [1:0]  os4;

`ifdef PG_RR_SCHED_CNT_EN
   logic        clr2, clr4;
   logic [15:0] gc2;
   logic [31:0] gc4;
`endif

   pg_rr_sched #(.WIDTH(4), .NREQ(2)) u_dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (v2),
      .req_data  (d2),
      .req_ready (rdy2),
      .out_valid (ov2),
      .out_ready (ordy2),
      .out_data  (od2),
      .out_src   (os2)
`ifdef PG_RR_SCHED_CNT_EN
      ,
      .cnt_clr   (clr2),
      .grant_cnt (gc2)
`endif
   );

   pg_rr_sched #(.WIDTH(4), .NREQ(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (v4),
      .req_data  (d4),
      .req_ready (rdy4),
      .out_valid (ov4),
      .out_ready (ordy4),
      .out_data  (od4),
      .out_src   (os4)
`ifdef PG_RR_SCHED_CNT_EN
      ,
      .cnt_clr   (clr4),
      .grant_cnt (gc4)
`endif
   );

   typedef struct {
      logic [1:0] v;
      logic [3:0] d0;
      logic [3:0] d1;
      logic       ordy;
      logic [1:0] rdy;   // expected req_ready this cycle
      logic       ov;    // expected out_valid this cycle (before the edge)
      logic       src;   // expected source of the beat granted this cycle
      logic [3:0] dat;   // expected data of the beat granted this cycle
   } vec_t;

   typedef struct {
      logic [1:0] src;
      logic [3:0] dat;
   } beat_t;

   beat_t q2[$];
   beat_t q4[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Compare the beat leaving the 2-requester output register.
   task automatic pop2(input string tag);
      beat_t b;
      if (q2.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s.sb2_underflow act=%0h/%0h exp=none", tag, os2, od2);
      end else begin
         b = q2.pop_front();
         chk({tag, ".src"}, 32'(os2), 32'(b.src));
         chk({tag, ".data"}, 32'(od2), 32'(b.dat));
      end
   endtask

   task automatic pop4(input string tag);
      beat_t b;
      if (q4.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s.sb4_underflow act=%0h/%0h exp=none", tag, os4, od4);
      end else begin
         b = q4.pop_front();
         chk({tag, ".src"}, 32'(os4), 32'(b.src));
         chk({tag, ".data"}, 32'(od4), 32'(b.dat));
      end
   endtask

   // One cycle on the 2-requester instance: drive after negedge, check
   // combinational ready and output state, retire/record beats.
   task automatic step2(input vec_t t, input string tag);
      @(negedge clk);
      v2    = t.v;
      d2    = {t.d1, t.d0};
      ordy2 = t.ordy;
      #1;
      chk({tag, ".ready"}, 32'(rdy2), 32'(t.rdy));
      chk({tag, ".ovalid"}, 32'(ov2), 32'(t.ov));
      if (ov2 && ordy2) pop2(tag);
      if (t.rdy != 2'b00) q2.push_back('{src: {1'b0, t.src}, dat: t.dat});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[17];
      vec_t t;
      logic [1:0] ord4[4];
      logic [3:0] exp_rdy4;

      // v, d0, d1, ordy, rdy, ov, src, dat
      tbl[0]  = '{2'b11, 4'h3, 4'hC, 1'b1, 2'b01, 1'b0, 1'b0, 4'h3};
      tbl[1]  = '{2'b11, 4'h3, 4'hC, 1'b1, 2'b10, 1'b1, 1'b1, 4'hC};
      tbl[2]  = '{2'b11, 4'h3, 4'hC, 1'b1, 2'b01, 1'b1, 1'b0, 4'h3};
      tbl[3]  = '{2'b11, 4'h3, 4'hC, 1'b1, 2'b10, 1'b1, 1'b1, 4'hC};
      tbl[4]  = '{2'b11, 4'h3, 4'hC, 1'b1, 2'b01, 1'b1, 1'b0, 4'h3};
      tbl[5]  = '{2'b11, 4'h3, 4'hC, 1'b0, 2'b00, 1'b1, 1'b0, 4'h0};
      tbl[6]  = '{2'b11, 4'h3, 4'hC, 1'b0, 2'b00, 1'b1, 1'b0, 4'h0};
      tbl[7]  = '{2'b11, 4'h3, 4'hC, 1'b0, 2'b00, 1'b1, 1'b0, 4'h0};
      tbl[8]  = '{2'b11, 4'h3, 4'hC, 1'b1, 2'b10, 1'b1, 1'b1, 4'hC};
      tbl[9]  = '{2'b10, 4'h0, 4'h5, 1'b1, 2'b10, 1'b1, 1'b1, 4'h5};
      tbl[10] = '{2'b10, 4'h0, 4'h5, 1'b1, 2'b10, 1'b1, 1'b1, 4'h5};
      tbl[11] = '{2'b10, 4'h0, 4'h5, 1'b1, 2'b10, 1'b1, 1'b1, 4'h5};
      tbl[12] = '{2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b1, 1'b0, 4'h0};
      tbl[13] = '{2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0};
      tbl[14] = '{2'b01, 4'hA, 4'h0, 1'b1, 2'b01, 1'b0, 1'b0, 4'hA};
      tbl[15] = '{2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b1, 1'b0, 4'h0};
      tbl[16] = '{2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0};

      ord4[0] = 2'd1;
      ord4[1] = 2'd3;
      ord4[2] = 2'd1;
      ord4[3] = 2'd3;

      rst_n = 1'b0;
      v2 = '0; d2 = '0; ordy2 = 1'b1;
      v4 = '0; d4 = {4'h4, 4'h3, 4'h2, 4'h1}; ordy4 = 1'b1;
`ifdef PG_RR_SCHED_CNT_EN
      clr2 = 1'b0;
      clr4 = 1'b0;
`endif

      // Reset state
      #12;
      chk("rst.ovalid", 32'(ov2), 32'd0);
      chk("rst.odata", 32'(od2), 32'd0);
      chk("rst.osrc", 32'(os2), 32'd0);
      chk("rst.ready", 32'(rdy2), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin, backpressure, single requester, idle
      for (int i = 0; i < 17; i++) begin
         step2(tbl[i], $sformatf("vec%0d", i));
      end

      // Asynchronous reset with a beat held in the output register
      @(negedge clk);
      v2 = 2'b11; d2 = {4'hC, 4'h3}; ordy2 = 1'b0;
      @(posedge clk);
      #2;
      chk("mid.pre_ovalid", 32'(ov2), 32'd1);
      v2 = 2'b00;
      rst_n = 1'b0;
      #1;
      chk("mid.ovalid", 32'(ov2), 32'd0);
      chk("mid.odata", 32'(od2), 32'd0);
      chk("mid.osrc", 32'(os2), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      t = '{2'b11, 4'h3, 4'hC, 1'b1, 2'b01, 1'b0, 1'b0, 4'h3};
      step2(t, "post_rst0");
      t = '{2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b1, 1'b0, 4'h0};
      step2(t, "post_rst1");
      t = '{2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0};
      step2(t, "post_rst2");

      // Wrap-around and fairness on 4 requesters (1 and 3 valid)
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         v4 = 4'b1010;
         ordy4 = 1'b1;
         #1;
         exp_rdy4 = 4'b0001 << ord4[k];
         chk($sformatf("wrap%0d.ready", k), 32'(rdy4), 32'(exp_rdy4));
         if (ov4 && ordy4) pop4($sformatf("wrap%0d", k));
         q4.push_back('{src: ord4[k], dat: 4'(ord4[k]) + 4'd1});
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         v4 = 4'b0000;
         #1;
         chk($sformatf("wrap_flush%0d.ready", k), 32'(rdy4), 32'd0);
         if (ov4 && ordy4) pop4($sformatf("wrap_flush%0d", k));
      end

      chk("sb2.empty", 32'(q2.size()), 32'd0);
      chk("sb4.empty", 32'(q4.size()), 32'd0);

`ifdef PG_RR_SCHED_CNT_EN
      // Saturating counters and clear-over-increment
      @(negedge clk);
      v2 = 2'b00; ordy2 = 1'b1; clr2 = 1'b1;
      @(negedge clk);
      clr2 = 1'b0;
      chk("cnt.cleared", 32'(gc2), 32'd0);
      for (int i = 0; i < 300; i++) begin
         v2 = 2'b01; d2 = 8'h01;
         @(negedge clk);
         if (i == 9) chk("cnt.ten", 32'(gc2[7:0]), 32'd10);
      end
      chk("cnt.sat", 32'(gc2[7:0]), 32'd255);
      chk("cnt.other", 32'(gc2[15:8]), 32'd0);
      clr2 = 1'b1;
      #1;
      chk("cnt.clr_grant", 32'(rdy2), 32'd1);
      @(negedge clk);
      clr2 = 1'b0;
      v2 = 2'b00;
      chk("cnt.clr_wins", 32'(gc2[7:0]), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
